// File: rtl/mpu_pkg.sv
// mpu_pkg: shared types and constants for the MPU-9150 sample UART link
// Contents: frame state enum, default header byte, burst size, 500 kbaud bit period.
// FRAMER_CHECKSUM_EN adds the ST_CSUM state to the frame enum.
package mpu_pkg;
  localparam int MPU_SAMPLE_BYTES = 14;
  localparam int UART_CLK_PER_BIT_500K = 100;
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEQ,
    ST_PAYLOAD,
`ifdef FRAMER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } frame_state_e;
endpackage

// File: rtl/mpu_sample_uart_framer_uart_tx_8n1.sv
// uart_tx_8n1: 8N1 UART transmitter with clear-to-send gating
// Ports: clk, rst (sync, active high); data[7:0] byte to send; start request;
//        cts allows a new byte to begin; tx serial line; idle ready for a byte.
module uart_tx_8n1
  import mpu_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT_500K
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  input  logic       cts,
  output logic       tx,
  output logic       idle
);
  localparam int CW = CLK_PER_BIT > 1 ? $clog2(CLK_PER_BIT) : 1;
  logic          busy_q, busy_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_end;
  assign bit_end = cnt_q == CW'(CLK_PER_BIT - 1);
  // Idle is raised during the final stop-bit cycle so a queued byte follows with no gap.
  assign idle = !busy_q || (bit_end && bit_q == 4'd9);
  assign tx = !busy_q || sh_q[0];
  always_comb begin
    busy_d = busy_q;
    sh_d = sh_q;
    bit_d = bit_q;
    cnt_d = cnt_q;
    if (busy_q) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      sh_d = bit_end ? {1'b1, sh_q[9:1]} : sh_q;
      bit_d = bit_end ? bit_q + 4'd1 : bit_q;
      busy_d = !(bit_end && bit_q == 4'd9);
    end
    if (start && cts && idle) begin
      busy_d = 1'b1;
      sh_d = {1'b1, data, 1'b0};
      bit_d = '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      sh_q <= '1;
      bit_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mpu_sample_uart_framer.sv
// mpu_sample_uart_framer: buffers one IMU sample burst and sends it as a UART frame
// Ports: clk, rst (sync, active high); in_data/in_valid/in_last/in_ready byte stream in;
//        avr_rx_busy blocks new bytes; tx UART line; busy frame held or sending;
//        overrun pulse on dropped byte or discarded burst; seq next frame number.
// Frame: HDR_BYTE, seq, SAMPLE_BYTES payload bytes; FRAMER_CHECKSUM_EN appends
//        XOR of seq and payload.
module mpu_sample_uart_framer
  import mpu_pkg::*;
#(
  parameter int         CLK_PER_BIT  = UART_CLK_PER_BIT_500K,
  parameter int         SAMPLE_BYTES = MPU_SAMPLE_BYTES,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       avr_rx_busy,
  output logic       tx,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] seq
);
`ifdef FRAMER_CHECKSUM_EN
  localparam frame_state_e ST_TAIL = ST_CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam frame_state_e ST_TAIL = ST_DONE;
`endif
  frame_state_e state_q, state_d;
  logic [7:0] mem_q [16];
  logic [4:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] seq_q, seq_d, tx_data, tail_byte;
  logic       locked_q, locked_d, overrun_q, overrun_d;
  logic       full, tx_start, tx_idle, fire;
  assign in_ready = !locked_q;
  assign busy = locked_q;
  assign overrun = overrun_q;
  assign seq = seq_q;
  assign full = wr_cnt_q + 5'd1 == 5'(SAMPLE_BYTES);
  assign tx_start = state_q != ST_IDLE && state_q != ST_DONE;
  assign fire = tx_start && tx_idle && !avr_rx_busy;
`ifdef FRAMER_CHECKSUM_EN
  assign tail_byte = state_q == ST_CSUM ? csum_q : mem_q[rd_cnt_q];
`else
  assign tail_byte = mem_q[rd_cnt_q];
`endif
  assign tx_data = state_q == ST_HDR ? HDR_BYTE : state_q == ST_SEQ ? seq_q : tail_byte;
  uart_tx_8n1 #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (tx_data),
    .start(tx_start),
    .cts  (!avr_rx_busy),
    .tx   (tx),
    .idle (tx_idle)
  );
  always_comb begin
    state_d = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    seq_d = seq_q;
    locked_d = locked_q;
    overrun_d = 1'b0;
`ifdef FRAMER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (in_valid && locked_q) overrun_d = 1'b1;
    else if (in_valid) begin
      wr_cnt_d = wr_cnt_q + 5'd1;
      // A burst ends on in_last or a full buffer; anything but both together is malformed.
      if (full || in_last) begin
        wr_cnt_d = '0;
        locked_d = full && in_last;
        overrun_d = !(full && in_last);
      end
    end
    case (state_q)
      ST_IDLE: state_d = locked_q ? ST_HDR : ST_IDLE;
      ST_HDR: state_d = fire ? ST_SEQ : ST_HDR;
      ST_SEQ: begin
        state_d = fire ? ST_PAYLOAD : ST_SEQ;
        rd_cnt_d = '0;
`ifdef FRAMER_CHECKSUM_EN
        csum_d = seq_q;
`endif
      end
      ST_PAYLOAD: if (fire) begin
        rd_cnt_d = rd_cnt_q + 4'd1;
        state_d = rd_cnt_q == 4'(SAMPLE_BYTES - 1) ? ST_TAIL : ST_PAYLOAD;
`ifdef FRAMER_CHECKSUM_EN
        csum_d = csum_q ^ mem_q[rd_cnt_q];
`endif
      end
`ifdef FRAMER_CHECKSUM_EN
      ST_CSUM: state_d = fire ? ST_DONE : ST_CSUM;
`endif
      // Hold until the last stop bit is on the line so busy covers the whole frame.
      ST_DONE: if (tx_idle) begin
        state_d = ST_IDLE;
        seq_d = seq_q + 8'd1;
        locked_d = 1'b0;
        wr_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) if (in_valid && !locked_q) mem_q[wr_cnt_q[3:0]] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      seq_q <= '0;
      locked_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef FRAMER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      seq_q <= seq_d;
      locked_q <= locked_d;
      overrun_q <= overrun_d;
`ifdef FRAMER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_mpu_sample_uart_framer.sv
// tb_mpu_sample_uart_framer: directed self-checking bench for the sample UART framer
module tb_mpu_sample_uart_framer;
`ifdef FRAMER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NF = 16 + CS;
  logic clk = 1'b0, rst = 1'b1, w_rst = 1'b1;
  logic [7:0] in_data = '0, w_in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, avr_rx_busy = 1'b0;
  logic w_in_valid = 1'b0, w_in_last = 1'b0, w_avr_rx_busy = 1'b0;
  logic tx, in_ready, busy, overrun, w_tx, w_in_ready, w_busy, w_overrun;
  logic [7:0] seq, w_seq;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] m_b [20];
  int m_t [20];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mpu_sample_uart_framer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .avr_rx_busy(avr_rx_busy), .tx(tx), .busy(busy),
    .overrun(overrun), .seq(seq)
  );
  mpu_sample_uart_framer #(.CLK_PER_BIT(2), .SAMPLE_BYTES(1), .HDR_BYTE(8'h5A)) dut_w (
    .clk(clk), .rst(w_rst), .in_data(w_in_data), .in_valid(w_in_valid), .in_last(w_in_last),
    .in_ready(w_in_ready), .avr_rx_busy(w_avr_rx_busy), .tx(w_tx), .busy(w_busy),
    .overrun(w_overrun), .seq(w_seq)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic rx_byte(input bit sel, output logic [7:0] b, output int t0);
    int cpb = sel ? 2 : 100;
    int n = 0;
    logic [9:0] f;
    while ((sel ? w_tx : tx) !== 1'b0 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8000) check("rx_timeout", 32'(sel ? w_tx : tx), 0);
    t0 = cyc;
    repeat (cpb / 2) @(negedge clk);
    f[0] = sel ? w_tx : tx;
    for (int i = 1; i < 10; i++) begin
      repeat (cpb) @(negedge clk);
      f[i] = sel ? w_tx : tx;
    end
    check("framing", {f[9], f[0]}, 2'b10);
    b = f[8:1];
  endtask
  task automatic rx_frame(input int n);
    for (int i = 0; i < n; i++) rx_byte(1'b0, m_b[i], m_t[i]);
  endtask
  task automatic check_frame(input logic [7:0] s, input logic [7:0] base, input int n, input int hold);
    logic [7:0] cs = s;
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = i == 0 ? 8'hA5 : i == 1 ? s : i < 16 ? base + 8'(i - 2) : cs;
      if (i >= 2 && i < 16) cs ^= e;
      check($sformatf("byte%0d", i), m_b[i], e);
      if (i > 0 && i != hold) check($sformatf("gap%0d", i), m_t[i] - m_t[i-1], 1000);
    end
  endtask
  task automatic send(input logic [7:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      in_data = base + 8'(i);
      in_last = i == last_at;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask
  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_seq", seq, 0);
    rst = 1'b0;
    w_rst = 1'b0;
    fork
      begin : main_flow
        int e0, d, ov, n;
        send(8'h00, 14, 13);
        e0 = cyc;
        check("lock_ready", in_ready, 0);
        check("lock_busy", busy, 1);
        check("lock_ovr", overrun, 0);
        fork
          rx_frame(NF);
          begin
            repeat (200) @(negedge clk);
            check("drop_ready", in_ready, 0);
            ov = 0;
            in_data = 8'hEE;
            in_valid = 1'b1;
            repeat (3) begin
              @(negedge clk);
              ov += int'(overrun);
            end
            in_valid = 1'b0;
            @(negedge clk);
            ov += int'(overrun);
            check("drop_ovr", ov, 3);
          end
        join
        check("hdr_latency", m_t[0] - e0, 2);
        check_frame(8'h00, 8'h00, NF, -1);
        while (cyc < m_t[NF-1] + 999) @(negedge clk);
        check("busy_stop", busy, 1);
        @(negedge clk);
        check("busy_done", busy, 0);
        check("seq_inc", seq, 1);
        check("ready_done", in_ready, 1);
        @(negedge clk);
        send(8'h10, 10, 9);
        check("short_ovr", overrun, 1);
        check("short_ready", in_ready, 1);
        send(8'h10, 14, -1);
        check("long_ovr", overrun, 1);
        ov = 0;
        repeat (50) begin
          @(negedge clk);
          ov += int'(!tx);
        end
        check("discard_tx", ov, 0);
        check("discard_busy", busy, 0);
        check("discard_seq", seq, 1);
        send(8'h20, 14, 13);
        fork
          rx_frame(NF);
          begin
            n = 0;
            while (tx && n < 100) begin
              @(negedge clk);
              n++;
            end
            avr_rx_busy = 1'b1;
            repeat (3000) @(negedge clk);
            check("hold_line", tx, 1);
            repeat (2000) @(negedge clk);
            avr_rx_busy = 1'b0;
            d = cyc;
          end
        join
        check("hold_resume", m_t[1] - d, 1);
        check_frame(8'h01, 8'h20, NF, 1);
        wait_idle();
        check("seq_f2", seq, 2);
        send(8'h40, 14, 13);
        rx_frame(4);
        check("pre_rst_seq", m_b[1], 2);
        check("pre_rst_p1", m_b[3], 8'h41);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_seq", seq, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        send(8'h50, 14, 13);
        rx_frame(NF);
        check_frame(8'h00, 8'h50, NF, -1);
        wait_idle();
        check("seq_after_rst", seq, 1);
      end
      begin : wrap_flow
        for (int k = 0; k < 257; k++) begin
          logic [7:0] b0, b1, b2, d8;
          int t, n;
          d8 = 8'(k) ^ 8'h3C;
          w_in_data = d8;
          w_in_valid = 1'b1;
          w_in_last = 1'b1;
          @(negedge clk);
          w_in_valid = 1'b0;
          w_in_last = 1'b0;
          rx_byte(1'b1, b0, t);
          rx_byte(1'b1, b1, t);
          rx_byte(1'b1, b2, t);
          check($sformatf("wrap%0d", k), {b0, b1, b2}, {8'h5A, 8'(k), d8});
`ifdef FRAMER_CHECKSUM_EN
          rx_byte(1'b1, b0, t);
          check("wrap_csum", b0, 8'h3C);
`endif
          n = 0;
          while (w_busy && n < 100) begin
            @(negedge clk);
            n++;
          end
          check("wrap_idle", w_busy, 0);
        end
        check("wrap_seq", w_seq, 1);
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
